// File: rtl/ddr3_traffic_checker.sv
// Write-then-read-back traffic generator/checker for the ddr3_memory_controller user port.
// Writes a programmable address range with a chosen pattern, reads it back pipelined, compares in order.
module ddr3_traffic_checker #(
  parameter int          DQ_BITWIDTH           = 16,
  parameter int          ADDRESS_BITWIDTH      = 15,
  parameter int          BANK_ADDRESS_BITWIDTH = 3,
  parameter int          MAX_OUTSTANDING       = 4,
  parameter int          ERR_COUNT_BITWIDTH    = 16,
  parameter logic [15:0] LFSR_SEED             = 16'hACE1,
  parameter logic [15:0] LFSR_TAPS             = 16'hB400
) (
  input  logic                                              clk,
  input  logic                                              resetn,
  input  logic                                              start,
  input  logic [1:0]                                        mode,
  input  logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] base_address,
  input  logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] num_words,
  input  logic                                              cmd_ready,
  output logic                                              write_enable,
  output logic                                              read_enable,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]                            i_user_data,
  input  logic                                              rd_data_valid,
  input  logic [DQ_BITWIDTH-1:0]                            o_user_data,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              pass,
  output logic [ERR_COUNT_BITWIDTH-1:0]                     error_count,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_address,
  output logic [DQ_BITWIDTH-1:0]                            first_error_expected,
  output logic [DQ_BITWIDTH-1:0]                            first_error_actual
);

  localparam int UA = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
  localparam int DQ = DQ_BITWIDTH;
  localparam logic [UA-1:0] ONE_UA     = UA'(1);
  localparam logic [UA-1:0] DQ_UA      = UA'(DQ_BITWIDTH);
  localparam logic [UA-1:0] MAX_OUT_UA = UA'(MAX_OUTSTANDING);
  localparam logic [DQ-1:0] SEED_DQ    = DQ'(LFSR_SEED);
  localparam logic [DQ-1:0] TAPS_DQ    = DQ'(LFSR_TAPS);
  localparam logic [DQ-1:0] WALK_ONE   = {{(DQ-1){1'b0}}, 1'b1};
  localparam logic [ERR_COUNT_BITWIDTH-1:0] ERR_ONE = ERR_COUNT_BITWIDTH'(1);
  localparam logic [ERR_COUNT_BITWIDTH-1:0] ERR_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [DQ-1:0] lfsr_step(input logic [DQ-1:0] s);
    lfsr_step = (s >> 1) ^ (s[0] ? TAPS_DQ : {DQ{1'b0}});
  endfunction

  function automatic logic [DQ-1:0] gen_pattern(input logic [1:0] m, input logic [UA-1:0] k,
                                                input logic [UA-1:0] addr, input logic [DQ-1:0] lfsr);
    logic [UA-1:0] sh;
    sh = k % DQ_UA;
    case (m)
      2'd0:    gen_pattern = DQ'(k);
      2'd1:    gen_pattern = lfsr;
      2'd2:    gen_pattern = WALK_ONE << sh;
      2'd3:    gen_pattern = DQ'(addr);
      default: gen_pattern = {DQ{1'b0}};
    endcase
  endfunction

  state_t                        state_q, state_d;
  logic [1:0]                    mode_q, mode_d;
  logic [UA-1:0]                 base_q, base_d, num_q, num_d;
  logic [UA-1:0]                 wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, rx_idx_q, rx_idx_d;
  logic [DQ-1:0]                 lfsr_wr_q, lfsr_wr_d, lfsr_rd_q, lfsr_rd_d;
  logic                          write_enable_q, write_enable_d, read_enable_q, read_enable_d;
  logic [UA-1:0]                 addr_q, addr_d;
  logic [DQ-1:0]                 wdata_q, wdata_d;
  logic                          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ERR_COUNT_BITWIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [UA-1:0]                 fe_addr_q, fe_addr_d;
  logic [DQ-1:0]                 fe_exp_q, fe_exp_d, fe_act_q, fe_act_d;

  logic          wr_acc_s, rd_acc_s, rsp_s, mism_s;
  logic [UA-1:0] rsp_addr_s, out_s, next_addr_s;
  logic [DQ-1:0] exp_s;

  // Next-state, command generation and response checking
  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    base_d         = base_q;
    num_d          = num_q;
    wr_idx_d       = wr_idx_q;
    lfsr_wr_d      = lfsr_wr_q;
    write_enable_d = write_enable_q;
    read_enable_d  = read_enable_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    busy_d         = busy_q;
    done_d         = done_q;
    pass_d         = pass_q;
    fe_addr_d      = fe_addr_q;
    fe_exp_d       = fe_exp_q;
    fe_act_d       = fe_act_q;
    next_addr_s    = base_q;

    wr_acc_s   = write_enable_q & cmd_ready;
    rd_acc_s   = read_enable_q & cmd_ready;
    // Responses only count while reads are actually outstanding
    rsp_s      = rd_data_valid && (state_q == S_READ || state_q == S_DRAIN) && (rx_idx_q != rd_idx_q);
    rsp_addr_s = base_q + rx_idx_q;
    exp_s      = gen_pattern(mode_q, rx_idx_q, rsp_addr_s, lfsr_rd_q);
    mism_s     = rsp_s && (o_user_data != exp_s);

    if (rsp_s) begin
      rx_idx_d  = rx_idx_q + ONE_UA;
      lfsr_rd_d = lfsr_step(lfsr_rd_q);
    end else begin
      rx_idx_d  = rx_idx_q;
      lfsr_rd_d = lfsr_rd_q;
    end

    if (mism_s) begin
      err_cnt_d = (err_cnt_q == ERR_MAX) ? err_cnt_q : err_cnt_q + ERR_ONE;
      if (err_cnt_q == '0) begin
        fe_addr_d = rsp_addr_s;
        fe_exp_d  = exp_s;
        fe_act_d  = o_user_data;
      end else begin
        fe_addr_d = fe_addr_q;
      end
    end else begin
      err_cnt_d = err_cnt_q;
    end

    rd_idx_d = rd_acc_s ? rd_idx_q + ONE_UA : rd_idx_q;
    out_s    = rd_idx_d - rx_idx_d;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d    = mode;
          base_d    = base_address;
          num_d     = num_words;
          wr_idx_d  = '0;
          rd_idx_d  = '0;
          rx_idx_d  = '0;
          lfsr_wr_d = SEED_DQ;
          lfsr_rd_d = SEED_DQ;
          err_cnt_d = '0;
          fe_addr_d = '0;
          fe_exp_d  = '0;
          fe_act_d  = '0;
          if (num_words == '0) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d        = S_WRITE;
            busy_d         = 1'b1;
            done_d         = 1'b0;
            pass_d         = 1'b0;
            write_enable_d = 1'b1;
            addr_d         = base_address;
            wdata_d        = gen_pattern(mode, '0, base_address, SEED_DQ);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (wr_acc_s) begin
          wr_idx_d    = wr_idx_q + ONE_UA;
          lfsr_wr_d   = lfsr_step(lfsr_wr_q);
          next_addr_s = base_q + wr_idx_d;
          if (wr_idx_d == num_q) begin
            state_d        = S_READ;
            write_enable_d = 1'b0;
            read_enable_d  = 1'b1;
            addr_d         = base_q;
          end else begin
            addr_d  = next_addr_s;
            wdata_d = gen_pattern(mode_q, wr_idx_d, next_addr_s, lfsr_wr_d);
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      S_READ: begin
        if (rd_idx_d == num_q) begin
          state_d       = S_DRAIN;
          read_enable_d = 1'b0;
        end else begin
          read_enable_d = (out_s < MAX_OUT_UA);
          addr_d        = base_q + rd_idx_d;
        end
      end
      S_DRAIN: begin
        if (rx_idx_d == num_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == '0);
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      mode_q         <= '0;
      base_q         <= '0;
      num_q          <= '0;
      wr_idx_q       <= '0;
      rd_idx_q       <= '0;
      rx_idx_q       <= '0;
      lfsr_wr_q      <= '0;
      lfsr_rd_q      <= '0;
      write_enable_q <= 1'b0;
      read_enable_q  <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      err_cnt_q      <= '0;
      fe_addr_q      <= '0;
      fe_exp_q       <= '0;
      fe_act_q       <= '0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      base_q         <= base_d;
      num_q          <= num_d;
      wr_idx_q       <= wr_idx_d;
      rd_idx_q       <= rd_idx_d;
      rx_idx_q       <= rx_idx_d;
      lfsr_wr_q      <= lfsr_wr_d;
      lfsr_rd_q      <= lfsr_rd_d;
      write_enable_q <= write_enable_d;
      read_enable_q  <= read_enable_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      err_cnt_q      <= err_cnt_d;
      fe_addr_q      <= fe_addr_d;
      fe_exp_q       <= fe_exp_d;
      fe_act_q       <= fe_act_d;
    end
  end

  assign write_enable         = write_enable_q;
  assign read_enable          = read_enable_q;
  assign i_user_data_address  = addr_q;
  assign i_user_data          = wdata_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign pass                 = pass_q;
  assign error_count          = err_cnt_q;
  assign first_error_address  = fe_addr_q;
  assign first_error_expected = fe_exp_q;
  assign first_error_actual   = fe_act_q;

endmodule

// File: tb/tb_ddr3_traffic_checker.sv
// Randomised bench for ddr3_traffic_checker: echo memory with configurable latency, stall and
// corruption, checked every cycle against a pattern/scoreboard model built from the pattern rules.
module tb_ddr3_traffic_checker;
  localparam int DQ   = 16;
  localparam int UA   = 18;
  localparam int MAXO = 4;
  localparam int AMOD = 1 << UA;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [UA-1:0] base_address = '0;
  logic [UA-1:0] num_words = '0;
  logic          cmd_ready = 1'b0;
  logic          rd_data_valid = 1'b0;
  logic [DQ-1:0] o_user_data = '0;
  logic          write_enable, read_enable, busy, done, pass;
  logic [UA-1:0] i_user_data_address, first_error_address;
  logic [DQ-1:0] i_user_data, first_error_expected, first_error_actual;
  logic [15:0]   error_count;

  ddr3_traffic_checker dut (
    .clk(clk), .resetn(resetn), .start(start), .mode(mode),
    .base_address(base_address), .num_words(num_words), .cmd_ready(cmd_ready),
    .write_enable(write_enable), .read_enable(read_enable),
    .i_user_data_address(i_user_data_address), .i_user_data(i_user_data),
    .rd_data_valid(rd_data_valid), .o_user_data(o_user_data),
    .busy(busy), .done(done), .pass(pass), .error_count(error_count),
    .first_error_address(first_error_address), .first_error_expected(first_error_expected),
    .first_error_actual(first_error_actual)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct { int addr; int due; } pend_t;
  logic [15:0] exp_data[$];
  pend_t       pend[$];
  logic [15:0] mem[int];
  int          wr_addr_log[$];
  logic [15:0] wr_data_log[$];
  int          rd_addr_log[$];
  int          wk, rk, rx, m_err, max_out;
  logic        m_first;
  int          fe_addr;
  logic [15:0] fe_exp, fe_act;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_we"}, write_enable, 0);
    chk({tag, "_re"}, read_enable, 0);
    chk({tag, "_addr"}, i_user_data_address, 0);
    chk({tag, "_wdata"}, i_user_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_errcnt"}, error_count, 0);
    chk({tag, "_feaddr"}, first_error_address, 0);
    chk({tag, "_feexp"}, first_error_expected, 0);
    chk({tag, "_feact"}, first_error_actual, 0);
  endtask

  task automatic run(input int m, input int base, input int num, input int rdy_pct,
                     input int lat, input int corrupt_idx, input int abort_rk);
    logic [15:0] lf, d, v;
    int a;
    logic finished, aborted;
    logic prev_we, prev_re, prev_rdy;
    logic [UA-1:0] prev_addr;
    logic [DQ-1:0] prev_data;

    exp_data.delete(); pend.delete(); mem.delete();
    wr_addr_log.delete(); wr_data_log.delete(); rd_addr_log.delete();
    lf = 16'hACE1;
    for (int k = 0; k < num; k++) begin
      a = (base + k) % AMOD;
      case (m)
        0:       d = 16'(k);
        1:       d = lf;
        2:       d = 16'd1 << (k % 16);
        default: d = 16'(a);
      endcase
      exp_data.push_back(d);
      lf = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
    end
    wk = 0; rk = 0; rx = 0; m_err = 0; max_out = 0; m_first = 1'b0;
    fe_addr = 0; fe_exp = '0; fe_act = '0;
    finished = 1'b0; aborted = 1'b0;
    prev_we = 1'b0; prev_re = 1'b0; prev_rdy = 1'b0; prev_addr = '0; prev_data = '0;

    @(negedge clk);
    start = 1'b1; mode = 2'(m); base_address = UA'(base); num_words = UA'(num);
    cmd_ready = 1'b0; rd_data_valid = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (t == 0 && num > 0) chk("first_write_latency", write_enable, 1);
      chk("we_re_exclusive", write_enable & read_enable, 0);
      chk("err_count_track", error_count, m_err);
      if (prev_we && !prev_rdy) begin
        chk("wr_hold_en", write_enable, 1);
        chk("wr_hold_addr", i_user_data_address, prev_addr);
        chk("wr_hold_data", i_user_data, prev_data);
      end
      if (prev_re && !prev_rdy) begin
        chk("rd_hold_en", read_enable, 1);
        chk("rd_hold_addr", i_user_data_address, prev_addr);
      end
      if (done) begin
        finished = 1'b1;
        break;
      end
      chk("busy_running", busy, 1);
      if (write_enable) begin
        chk("wr_in_range", wk < num, 1);
        if (wk < num) begin
          chk("wr_addr", i_user_data_address, (base + wk) % AMOD);
          chk("wr_data", i_user_data, exp_data[wk]);
        end
      end
      if (read_enable) begin
        chk("rd_in_range", rk < num, 1);
        chk("rd_after_writes", wk, num);
        chk("rd_addr", i_user_data_address, (base + rk) % AMOD);
      end
      if (abort_rk > 0 && rk >= abort_rk) begin
        aborted = 1'b1;
        break;
      end
      // Drive the next edge: stalls, random restarts and input churn that must be ignored
      cmd_ready = ($urandom_range(0, 99) < rdy_pct);
      start = ($urandom_range(0, 7) == 0);
      mode = 2'($urandom);
      base_address = UA'($urandom);
      num_words = UA'($urandom);
      if (write_enable && cmd_ready) begin
        mem[int'(i_user_data_address)] = i_user_data;
        wr_addr_log.push_back(int'(i_user_data_address));
        wr_data_log.push_back(i_user_data);
        wk++;
      end
      if (read_enable && cmd_ready) begin
        pend.push_back('{addr: int'(i_user_data_address), due: t + lat});
        rd_addr_log.push_back(int'(i_user_data_address));
        rk++;
      end
      if (pend.size() > 0 && pend[0].due <= t) begin
        a = pend[0].addr;
        v = mem.exists(a) ? mem[a] : 16'hDEAD;
        if (corrupt_idx >= 0 && a == (base + corrupt_idx) % AMOD) v = v ^ 16'h0001;
        rd_data_valid = 1'b1;
        o_user_data = v;
        if (rx < num && v !== exp_data[rx]) begin
          if (m_err < 65535) m_err++;
          if (!m_first) begin
            m_first = 1'b1; fe_addr = (base + rx) % AMOD; fe_exp = exp_data[rx]; fe_act = v;
          end
        end
        rx++;
        void'(pend.pop_front());
      end else begin
        rd_data_valid = 1'b0;
        o_user_data = 16'($urandom);
      end
      if (rk - rx > max_out) max_out = rk - rx;
      chk("outstanding_le_max", (rk - rx) <= MAXO, 1);
      prev_we = write_enable; prev_re = read_enable; prev_rdy = cmd_ready;
      prev_addr = i_user_data_address; prev_data = i_user_data;
    end
    start = 1'b0;

    if (aborted) begin
      resetn = 1'b0; cmd_ready = 1'b1; rd_data_valid = 1'b1; o_user_data = 16'($urandom);
      @(negedge clk);
      check_all_zero("abort");
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      chk("late_rsp_errcnt", error_count, 0);
      chk("late_rsp_busy", busy, 0);
      chk("late_rsp_we", write_enable, 0);
      chk("late_rsp_re", read_enable, 0);
      rd_data_valid = 1'b0;
    end else begin
      chk("run_finished_in_budget", finished, 1);
      chk("done_busy", busy, 0);
      chk("done_we", write_enable, 0);
      chk("done_re", read_enable, 0);
      chk("done_pass", pass, m_err == 0);
      chk("done_errcnt", error_count, m_err);
      chk("writes_total", wk, num);
      chk("reads_total", rk, num);
      chk("responses_total", rx, num);
      chk("fe_addr", first_error_address, fe_addr);
      chk("fe_expected", first_error_expected, fe_exp);
      chk("fe_actual", first_error_actual, fe_act);
      rd_data_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("done_sticky", done, 1);
      chk("pass_sticky", pass, m_err == 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  initial begin
    int rm, rb, rn, rr, rl, rc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    resetn = 1'b1;

    run(0, 0, 8, 100, 1, -1, 0);
    chk("t1_write_count", wr_data_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_wdata_literal", wr_data_log[i], i);
      chk("t1_raddr_literal", rd_addr_log[i], i);
    end
    chk("t1_pass", pass, 1);

    run(1, 'h1000, 32, 50, 3, -1, 0);
    chk("t2_lfsr_word0", wr_data_log[0], 16'hACE1);
    chk("t2_lfsr_word1", wr_data_log[1], 16'hE270);
    chk("t2_pass", pass, 1);

    run(2, 100, 12, 70, 2, 5, 0);
    chk("t3_errcnt", error_count, 1);
    chk("t3_fe_addr", first_error_address, 105);
    chk("t3_fe_exp", first_error_expected, 16'h0020);
    chk("t3_fe_act", first_error_actual, 16'h0021);
    chk("t3_pass", pass, 0);

    run(3, AMOD - 2, 4, 100, 2, -1, 0);
    chk("t4_addr0", wr_addr_log[0], 262142);
    chk("t4_addr1", wr_addr_log[1], 262143);
    chk("t4_addr2", wr_addr_log[2], 0);
    chk("t4_addr3", wr_addr_log[3], 1);
    chk("t4_data1", wr_data_log[1], 16'hFFFF);
    chk("t4_pass", pass, 1);

    run(0, 50, 16, 100, 20, -1, 0);
    chk("t5_max_outstanding", max_out, 4);
    run(0, 7, 0, 100, 1, -1, 0);
    chk("t5_zero_no_cmds", wr_addr_log.size() + rd_addr_log.size(), 0);
    chk("t5_zero_pass", pass, 1);

    run(0, 0, 16, 100, 5, -1, 3);
    run(1, 300, 10, 80, 2, -1, 0);
    chk("t6_rerun_pass", pass, 1);

    for (int r = 0; r < 6; r++) begin
      rm = $urandom_range(0, 3);
      rb = $urandom_range(0, AMOD - 1);
      rn = $urandom_range(1, 40);
      rr = $urandom_range(30, 100);
      rl = $urandom_range(1, 8);
      rc = ($urandom_range(0, 1) == 1) ? $urandom_range(0, rn - 1) : -1;
      run(rm, rb, rn, rr, rl, rc, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
